// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encodings, IO address tag and length codes for mem_arbiter.
// MEM_ARBITER_RR_EN selects round-robin grants on contended requests.
package mem_arbiter_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_IREAD, ST_DREAD, ST_DWRITE, ST_IOWAIT, ST_DONE} state_t;
    localparam logic [1:0] IO_TAG = 2'b11;
    localparam logic [2:0] LEN_1 = 3'd1;
    localparam logic [2:0] LEN_2 = 3'd2;
    localparam logic [2:0] LEN_4 = 3'd4;
`ifdef MEM_ARBITER_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif
    function automatic logic is_io(input logic [31:0] a);
        return a[17:16] == IO_TAG;
    endfunction
    // Unsupported lengths collapse to a single byte.
    function automatic logic [2:0] norm_len(input logic [2:0] l);
        return (l == LEN_4) ? LEN_4 : (l == LEN_2) ? LEN_2 : LEN_1;
    endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant selection; data-first, or alternating ties under MEM_ARBITER_RR_EN.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic ireq_i,
    input  logic dreq_i,
    input  logic ptr_i,
    output logic gnt_i_o,
    output logic gnt_d_o
);
    // ptr_i high means data won last, so instruction takes the next tie.
    assign gnt_d_o = dreq_i && !(ireq_i && RR_EN && ptr_i);
    assign gnt_i_o = ireq_i && !gnt_d_o;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port byte memory arbiter for instruction and data requests.
// Build with MEM_ARBITER_RR_EN for round-robin tie breaking.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        flush,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [2:0]  d_len,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        busy
);
    state_t      state_q;
    logic [2:0]  cnt_q, len_q, cnt_d;
    logic [31:0] base_q, wdata_q, rbuf_q, mem_a_q, i_data_q, d_rdata_q, cap_d;
    logic [7:0]  mem_dout_q, wbyte_d;
    logic        wr_q, i_done_q, d_done_q, ptr_q, gnt_i, gnt_d;

    mem_arb_pick u_pick (
        .ireq_i (i_req),
        .dreq_i (d_req),
        .ptr_i  (ptr_q),
        .gnt_i_o(gnt_i),
        .gnt_d_o(gnt_d)
    );

    // mem_din belongs to the address issued one cycle earlier, hence lane cnt_q-1.
    always_comb begin
        cnt_d = cnt_q + 3'd1;
        cap_d = rbuf_q;
        cap_d[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
        wbyte_d = wdata_q[{cnt_d[1:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            wr_q       <= 1'b0;
            i_data_q   <= '0;
            d_rdata_q  <= '0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            ptr_q      <= 1'b0;
        end else if (rdy_in) begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (!flush && (gnt_i || gnt_d)) begin
                    ptr_q   <= gnt_d;
                    cnt_q   <= '0;
                    rbuf_q  <= '0;
                    base_q  <= gnt_d ? d_addr : i_addr;
                    len_q   <= gnt_d ? norm_len(d_len) : LEN_4;
                    wdata_q <= d_wdata;
                    if (gnt_d && d_wr && is_io(d_addr) && io_buffer_full) begin
                        state_q <= ST_IOWAIT;
                    end else begin
                        state_q    <= gnt_i ? ST_IREAD : d_wr ? ST_DWRITE : ST_DREAD;
                        mem_a_q    <= gnt_d ? d_addr : i_addr;
                        wr_q       <= gnt_d && d_wr;
                        mem_dout_q <= (gnt_d && d_wr) ? d_wdata[7:0] : 8'h00;
                    end
                end
                ST_IREAD, ST_DREAD: if (flush) begin
                    state_q <= ST_IDLE;
                    mem_a_q <= '0;
                    rbuf_q  <= '0;
                end else if (cnt_q == len_q) begin
                    state_q <= ST_DONE;
                    rbuf_q  <= cap_d;
                    if (state_q == ST_IREAD) begin
                        i_data_q <= cap_d;
                        i_done_q <= 1'b1;
                    end else begin
                        d_rdata_q <= cap_d;
                        d_done_q  <= 1'b1;
                    end
                end else begin
                    if (cnt_q != 3'd0) rbuf_q <= cap_d;
                    cnt_q   <= cnt_d;
                    mem_a_q <= (cnt_d < len_q) ? base_q + 32'(cnt_d) : '0;
                end
                ST_DWRITE: if (cnt_d == len_q) begin
                    state_q    <= ST_DONE;
                    d_done_q   <= 1'b1;
                    wr_q       <= 1'b0;
                    mem_a_q    <= '0;
                    mem_dout_q <= '0;
                end else begin
                    cnt_q      <= cnt_d;
                    mem_a_q    <= base_q + 32'(cnt_d);
                    mem_dout_q <= wbyte_d;
                end
                ST_IOWAIT: if (!io_buffer_full) begin
                    state_q    <= ST_DWRITE;
                    cnt_q      <= '0;
                    mem_a_q    <= base_q;
                    mem_dout_q <= wdata_q[7:0];
                    wr_q       <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_wr   = wr_q && rdy_in;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign i_data   = i_data_q;
    assign i_done   = i_done_q;
    assign d_rdata  = d_rdata_q;
    assign d_done   = d_done_q;
    assign busy     = state_q != ST_IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against hand-computed cycle traces.
module tb_mem_arbiter;
    logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
    logic [7:0]  mem_din = '0, mem_dout;
    logic [31:0] mem_a, i_addr = '0, i_data, d_addr = '0, d_wdata = '0, d_rdata;
    logic        mem_wr, io_buffer_full = 1'b0, flush = 1'b0;
    logic        i_req = 1'b0, i_done, d_req = 1'b0, d_wr = 1'b0, d_done, busy;
    logic [2:0]  d_len = '0;
    logic [31:0] last_a = '0;
    int          passed = 0, total = 0;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .flush(flush),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_len(d_len), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    // Memory contents: 13,00,00,00 at 0x100, otherwise low address byte plus 0x11.
    function automatic logic [7:0] byte_of(input logic [31:0] a);
        if (a >= 32'h100 && a <= 32'h103) return (a == 32'h100) ? 8'h13 : 8'h00;
        return a[7:0] + 8'h11;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one cycle; memory answers the previous cycle's address and stalls with rdy_in.
    task automatic tick();
        logic en;
        en = rdy_in;
        @(posedge clk_in);
        #1;
        if (en) begin
            mem_din = byte_of(last_a);
            last_a  = mem_a;
        end
    endtask

    task automatic run_out();
        int n;
        n = 0;
        while (busy && n < 40) begin
            if (i_done) i_req = 1'b0;
            if (d_done) d_req = 1'b0;
            tick();
            n++;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk("drain", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_bus", {mem_wr, mem_a, mem_dout}, 0);
        chk("rst_done", {i_done, d_done}, 0);
        chk("rst_data", {i_data, d_rdata}, 0);
        @(negedge clk_in) rst_in = 1'b1;
        tick();

        // 4-byte fetch from 0x100
        i_req = 1'b1; i_addr = 32'h100;
        tick();
        chk("if_busy", busy, 1);
        chk("if_a0", mem_a, 32'h100);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("if_ak", mem_a, 32'h100 + k);
        end
        tick();
        chk("if_c4", {i_done, mem_a}, 0);
        tick();
        chk("if_done", {i_done, i_data}, {1'b1, 32'h13});
        i_req = 1'b0;
        tick();
        chk("if_idle", {busy, i_done}, 0);

        // 2-byte store
        d_req = 1'b1; d_wr = 1'b1; d_len = 3'd2; d_addr = 32'h2000; d_wdata = 32'hBEEF;
        tick();
        chk("wr_b0", {mem_wr, mem_a, mem_dout, d_done}, {1'b1, 32'h2000, 8'hEF, 1'b0});
        tick();
        chk("wr_b1", {mem_wr, mem_a, mem_dout, d_done}, {1'b1, 32'h2001, 8'hBE, 1'b0});
        tick();
        chk("wr_done", {mem_wr, mem_a, mem_dout, d_done}, {1'b0, 32'h0, 8'h00, 1'b1});
        d_req = 1'b0;
        tick();
        chk("wr_idle", busy, 0);

        // contention: data first, then fixed or alternating
        i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_wr = 1'b0; d_len = 3'd1; d_addr = 32'h40;
        tick();
        chk("tie1", mem_a, 32'h40);
        run_out();
        chk("tie1_data", d_rdata, 32'h51);
        i_req = 1'b1; d_req = 1'b1;
        tick();
`ifdef MEM_ARBITER_RR_EN
        chk("tie2", mem_a, 32'h200);
`else
        chk("tie2", mem_a, 32'h40);
`endif
        run_out();

        // flush with a request in IDLE drops it; flush mid-fetch aborts
        i_req = 1'b1; i_addr = 32'h300; flush = 1'b1;
        tick();
        chk("fl_idle", busy, 0);
        flush = 1'b0;
        tick();
        chk("fl_a0", mem_a, 32'h300);
        tick();
        tick();
        flush = 1'b1;
        tick();
        chk("fl_abort", {busy, i_done, mem_a}, 0);
        flush = 1'b0; i_addr = 32'h400;
        tick();
        chk("fl_regrant", {busy, mem_a}, {1'b1, 32'h400});
        run_out();
        chk("fl_data", i_data, 32'h14131211);

        // 2-byte load wrapping past 0xFFFFFFFF, zero-extended
        d_req = 1'b1; d_wr = 1'b0; d_len = 3'd2; d_addr = 32'hFFFF_FFFF;
        tick();
        chk("wrap_a0", mem_a, 32'hFFFF_FFFF);
        tick();
        chk("wrap_a1", {busy, mem_a}, {1'b1, 32'h0});
        run_out();
        chk("wrap_data", d_rdata, 32'h0000_1110);

        // IO write held off while the uart buffer is full; flush ignored meanwhile
        d_req = 1'b1; d_wr = 1'b1; d_len = 3'd1; d_addr = 32'h30000; d_wdata = 32'hA5;
        io_buffer_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            flush = (k == 1);
            chk("io_wait", {busy, mem_wr}, 2'b10);
            if (k == 4) io_buffer_full = 1'b0;
        end
        tick();
        chk("io_write", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h30000, 8'hA5});
        tick();
        chk("io_done", {d_done, mem_wr}, 2'b10);
        run_out();

        // rdy_in stall re-issues the current store byte
        d_req = 1'b1; d_wr = 1'b1; d_len = 3'd2; d_addr = 32'h700; d_wdata = 32'hABCD;
        tick();
        chk("st_b0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h700, 8'hCD});
        rdy_in = 1'b0;
        #1;
        chk("st_wr0", mem_wr, 0);
        tick();
        chk("st_held", {mem_wr, mem_a, mem_dout, busy}, {1'b0, 32'h700, 8'hCD, 1'b1});
        rdy_in = 1'b1;
        #1;
        chk("st_reissue", {mem_wr, mem_a}, {1'b1, 32'h700});
        tick();
        chk("st_b1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h701, 8'hAB});
        run_out();

        // reset in the middle of a 4-byte store
        d_req = 1'b1; d_wr = 1'b1; d_len = 3'd4; d_addr = 32'h500; d_wdata = 32'h11223344;
        tick();
        tick();
        tick();
        chk("rs_b2", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h502, 8'h22});
        rst_in = 1'b0;
        #1;
        chk("rs_async", {busy, mem_wr, d_done, mem_a}, 0);
        tick();
        chk("rs_hold", {busy, d_done}, 0);
        rst_in = 1'b1; d_len = 3'd1;
        tick();
        chk("rs_regrant", {mem_wr, mem_a, mem_dout, d_done}, {1'b1, 32'h500, 8'h44, 1'b0});
        run_out();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk_in  in  1  system clock; all state updates on rising edge.
REQ-003 rst_in  in  1  asynchronous, active-low reset.
REQ-004 rdy_in  in  1  global ready; low freezes all state, outputs held.
REQ-005 mem_din  in  8  byte read bus; valid one cycle after address.
REQ-006 mem_dout  out  8  byte write bus.
REQ-007 mem_a  out  32  byte address.
REQ-008 mem_wr  out  1  1 = write.
REQ-009 io_buffer_full  in  1  uart tx buffer full.
REQ-010 flush  in  1  misprediction clear; aborts reads.
REQ-011 i_req/i_addr  in  1/32  instruction fetch request; 4-byte read; level-held until i_done.
REQ-012 i_data/i_done  out  32/1  fetched word; i_done one-cycle pulse.
REQ-013 d_req/d_wr/d_len/d_addr/d_wdata  in  1/1/3/32/32  data request; d_len in {1,2,4} bytes; level-held until d_done.
REQ-014 d_rdata/d_done  out  32/1  zero-extended read data; d_done one-cycle pulse.
REQ-015 busy  out  1  high in any state except IDLE.

Function
REQ-016 FSM states: IDLE, IREAD, DREAD, DWRITE, IOWAIT, DONE.
REQ-017 In IDLE, a request sampled high moves the FSM to its state on the next edge (grant edge), with byte-0 address registered onto mem_a.
REQ-018 Reads are pipelined: the address of byte k is on mem_a in cycle k after grant, and mem_din is captured into byte lane k in cycle k+1.
REQ-019 An N-byte read pulses done in cycle N+1 after grant, with full data valid the same cycle.
REQ-020 Writes drive mem_wr=1 with byte k of d_wdata (little-endian) on mem_dout in cycle k, for N cycles; d_done pulses in cycle N.
REQ-021 Byte address = base + k; 32-bit wrap is permitted, with no alignment check.
REQ-022 Fixed priority (macro off): when d_req and i_req are both high in IDLE, data wins; instruction waits.
REQ-023 At most one transaction is in flight; a new grant is possible in the cycle after the done pulse, which returns the FSM to IDLE.
REQ-024 IO write: address with [17:16]==2'b11 while io_buffer_full=1 enters IOWAIT with mem_wr=0, resuming the write the cycle after io_buffer_full falls.
REQ-025 Flush during IREAD or DREAD returns the FSM to IDLE next edge, suppresses done, and discards captured bytes.
REQ-026 Flush during DWRITE or IOWAIT is ignored; stores always complete.
REQ-027 Flush in the same cycle as a new request in IDLE drops that request (no grant).
REQ-028 Outside active read/write cycles: mem_wr=0, mem_a=0, mem_dout=0.
REQ-029 rdy_in low mid-transaction: mem_wr forced 0 and byte counter frozen; on resume, the current byte is re-issued (its read re-captured).

Reset
REQ-030 rst_in low asynchronously sets FSM=IDLE, counter=0, all outputs 0, and the round-robin pointer to data-first.
REQ-031 Reset mid-transaction abandons it with no done pulse; after release, a request is granted on the first rising edge where it is sampled high.

Configuration
REQ-032 Macro MEM_ARBITER_RR_EN: when defined, contended grants alternate, with the last-granted port losing the next tie; when undefined, fixed data priority per REQ-022.
REQ-033 In both modes, an uncontended request is granted immediately.

Structure
REQ-034 Shared package/const file holds state encodings, the IO address tag (2'b11 at [17:16]), and length codes 1/2/4.
REQ-035 One sub-module, mem_arb_pick, holds the combinational grant selection (priority/RR pointer), keeping the FSM and byte sequencer in mem_arbiter.

Verification
REQ-036 i_req, i_addr=0x100, mem bytes 13,00,00,00 -> mem_a 0x100..0x103 in cycles 0..3, i_done in cycle 5, i_data=0x00000013.
REQ-037 d_req, d_wr=1, d_len=2, d_addr=0x2000, d_wdata=0xBEEF -> mem_wr in 2 cycles, with (0x2000, EF) then (0x2001, BE), then d_done.
REQ-038 i_req and d_req raised together -> data granted first; with MEM_ARBITER_RR_EN, a second simultaneous pair grants instruction.
REQ-039 flush in cycle 2 of a 4-byte IREAD -> no i_done, IDLE next cycle, and a new i_req is granted the cycle after.
REQ-040 IO write to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0 for those 5 cycles, the write occurs the cycle after full drops, then d_done.
REQ-041 rst_in low in cycle 2 of DWRITE -> mem_wr=0 immediately, busy=0, and no d_done.
